// File: rtl/assay_pkg.sv
// Shared types and step-word layout for the assay step sequencer.
// Step word layout, LSB first: dwell, src, route, mix, last.
package assay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        RUN,
        WASH,
        DONE
    } state_t;

    localparam logic ROUTE_CONTROL = 1'b0;
    localparam logic ROUTE_OUT     = 1'b1;

    function automatic int src_w(int n_sources);
        return $clog2(n_sources);
    endfunction

    function automatic int src_lsb(int dwell_w);
        return dwell_w;
    endfunction

    function automatic int route_bit(int n_sources, int dwell_w);
        return dwell_w + src_w(n_sources);
    endfunction

    function automatic int mix_bit(int n_sources, int dwell_w);
        return route_bit(n_sources, dwell_w) + 1;
    endfunction

    function automatic int last_bit(int n_sources, int dwell_w);
        return route_bit(n_sources, dwell_w) + 2;
    endfunction

    function automatic int step_w(int n_sources, int dwell_w);
        return route_bit(n_sources, dwell_w) + 3;
    endfunction

endpackage

// File: rtl/assay_step_sequencer_step_mem.sv
// Step program store: single write port, registered read port.
module assay_step_sequencer_step_mem #(
    parameter int DEPTH = 8,
    parameter int SW    = 18
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [SW-1:0]            rdata
);

    logic [SW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/assay_step_sequencer.sv
// Programmable valve/mixer step sequencer for immunoassay chips.
// Optional WASH_INSERT_EN adds a wash phase between consecutive steps.
module assay_step_sequencer
    import assay_pkg::*;
#(
    parameter int N_SOURCES   = 5,
    parameter int DEPTH       = 8,
    parameter int DWELL_W     = 12
`ifdef WASH_INSERT_EN
    ,
    parameter int WASH_CYCLES = 16,
    parameter int WASH_SRC    = 0
`endif
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     prog_we,
    input  logic [$clog2(DEPTH)-1:0]                 prog_addr,
    input  logic [step_w(N_SOURCES, DWELL_W)-1:0]    prog_data,
    input  logic                                     start,
    input  logic                                     abort,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     aborted,
    output logic                                     err,
    output logic [N_SOURCES-1:0]                     src_sel,
    output logic                                     mixer_en,
    output logic                                     route_out,
    output logic [$clog2(DEPTH)-1:0]                 step_idx
);

    localparam int IW      = $clog2(DEPTH);
    localparam int SRC_W   = src_w(N_SOURCES);
    localparam int SW      = step_w(N_SOURCES, DWELL_W);
    localparam int SRC_LSB = src_lsb(DWELL_W);
    localparam int ROUTE_B = route_bit(N_SOURCES, DWELL_W);
    localparam int MIX_B   = mix_bit(N_SOURCES, DWELL_W);
    localparam int LAST_B  = last_bit(N_SOURCES, DWELL_W);

    localparam logic [N_SOURCES-1:0] ONE      = 1;
    localparam logic [IW-1:0]        LAST_IDX = IW'(DEPTH - 1);
    localparam logic [SRC_W:0]       N_SRC_V  = (SRC_W + 1)'(N_SOURCES);

    state_t               state;
    logic [DWELL_W-1:0]   cnt;
    logic                 last_q;
    logic [SW-1:0]        rd_data;

    logic [DWELL_W-1:0]   f_dwell;
    logic [SRC_W-1:0]     f_src;
    logic                 f_route;
    logic                 f_mix;
    logic                 f_last;
    logic                 bad_src;

    assign f_dwell = rd_data[DWELL_W-1:0];
    assign f_src   = rd_data[SRC_LSB +: SRC_W];
    assign f_route = rd_data[ROUTE_B];
    assign f_mix   = rd_data[MIX_B];
    assign f_last  = rd_data[LAST_B];
    assign bad_src = {1'b0, f_src} >= N_SRC_V;

    assay_step_sequencer_step_mem #(
        .DEPTH (DEPTH),
        .SW    (SW)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (step_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            src_sel   <= '0;
            mixer_en  <= 1'b0;
            route_out <= ROUTE_CONTROL;
            step_idx  <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                aborted   <= 1'b1;
                src_sel   <= '0;
                mixer_en  <= 1'b0;
                route_out <= ROUTE_CONTROL;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            step_idx <= '0;
                            err      <= 1'b0;
                        end
                    end
                    FETCH: state <= CHECK;
                    CHECK: begin
                        if (bad_src) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt       <= (f_dwell == '0) ? DWELL_W'(1) : f_dwell;
                            last_q    <= f_last;
                            src_sel   <= ONE << f_src;
                            mixer_en  <= f_mix;
                            route_out <= f_route;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == DWELL_W'(1)) begin
                            src_sel   <= '0;
                            mixer_en  <= 1'b0;
                            route_out <= ROUTE_CONTROL;
                            if (last_q || step_idx == LAST_IDX) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
`ifdef WASH_INSERT_EN
                                state   <= WASH;
                                cnt     <= DWELL_W'(WASH_CYCLES);
                                src_sel <= ONE << WASH_SRC;
`else
                                step_idx <= step_idx + 1'b1;
                                state    <= FETCH;
`endif
                            end
                        end
                    end
`ifdef WASH_INSERT_EN
                    WASH: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == DWELL_W'(1)) begin
                            src_sel  <= '0;
                            step_idx <= step_idx + 1'b1;
                            state    <= FETCH;
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_assay_step_sequencer.sv
// Scoreboard bench for assay_step_sequencer (default parameters).
// Expected per-cycle output vectors are queued from a behavioural model.
module tb_assay_step_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [17:0] prog_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;
    logic [4:0]  src_sel;
    logic        mixer_en;
    logic        route_out;
    logic [2:0]  step_idx;

    int checks = 0;
    int failures = 0;

    logic [17:0] shadow [8];
    logic [13:0] q [$];

    assay_step_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err),
        .src_sel   (src_sel),
        .mixer_en  (mixer_en),
        .route_out (route_out),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ev(bit b, bit d, bit a, bit e,
                                       logic [4:0] s, bit m, bit r,
                                       logic [2:0] i);
        return {b, d, a, e, s, m, r, i};
    endfunction

    function automatic logic [13:0] obs();
        return {busy, done, aborted, err, src_sel, mixer_en, route_out, step_idx};
    endfunction

    task automatic chk(string tag, logic [13:0] o, logic [13:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic prog(int a, bit l, bit m, bit r, int s, int d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a[2:0];
        prog_data = {l, m, r, s[2:0], d[11:0]};
        shadow[a] = prog_data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Expected trace, one entry per cycle after the start edge.
    task automatic build();
        int i;
        int d;
        bit fin;
        logic [17:0] w;
        logic [2:0] s;
        i = 0;
        fin = 1'b0;
        while (!fin) begin
            w = shadow[i];
            s = w[14:12];
            q.push_back(ev(1, 0, 0, 0, '0, 0, 0, i[2:0]));
            q.push_back(ev(1, 0, 0, 0, '0, 0, 0, i[2:0]));
            if (s >= 3'd5) begin
                q.push_back(ev(0, 0, 0, 1, '0, 0, 0, i[2:0]));
                fin = 1'b1;
            end else begin
                d = (w[11:0] == 12'd0) ? 1 : int'(w[11:0]);
                repeat (d) q.push_back(ev(1, 0, 0, 0, 5'(1) << s, w[16], w[15], i[2:0]));
                if (w[17] || i == 7) begin
                    q.push_back(ev(1, 1, 0, 0, '0, 0, 0, i[2:0]));
                    q.push_back(ev(0, 0, 0, 0, '0, 0, 0, i[2:0]));
                    fin = 1'b1;
                end else begin
`ifdef WASH_INSERT_EN
                    repeat (16) q.push_back(ev(1, 0, 0, 0, 5'b00001, 0, 0, i[2:0]));
`endif
                    i++;
                end
            end
        end
    endtask

    task automatic run(int tid, int abort_at, int we_at);
        int c;
        logic [13:0] e;
        @(negedge clk);
        start = 1'b1;
        c = 0;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            prog_we = 1'b0;
            c++;
            e = q.pop_front();
            chk($sformatf("t%0d_c%0d", tid, c), obs(), e);
            if (c == abort_at) abort = 1'b1;
            if (c == we_at) begin
                prog_we   = 1'b1;
                prog_addr = 3'd0;
                prog_data = {1'b0, 1'b0, 1'b0, 3'd3, 12'd2};
            end
        end
    endtask

    task automatic prog_t1();
        prog(0, 0, 0, 0, 1, 4);
        prog(1, 0, 1, 0, 4, 10);
        prog(2, 1, 0, 1, 2, 3);
    endtask

    initial begin
        logic [2:0] ai;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", obs(), ev(0, 0, 0, 0, '0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_idle", obs(), ev(0, 0, 0, 0, '0, 0, 0, 0));

        // three-step program
        prog_t1();
        build();
        run(1, 0, 0);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", obs(), ev(0, 0, 0, 0, '0, 0, 0, 2));
        @(posedge clk);
        #1;
        chk("start_abort2", obs(), ev(0, 0, 0, 0, '0, 0, 0, 2));

        // invalid source index
        prog(0, 1, 0, 0, 6, 5);
        build();
        run(3, 0, 0);
        @(posedge clk);
        #1;
        chk("err_sticky", obs(), ev(0, 0, 0, 1, '0, 0, 0, 0));

        // dwell 0, written in the same cycle as start; clears err
        @(posedge clk);
        #1;
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = {1'b1, 1'b1, 1'b0, 3'd3, 12'd0};
        shadow[0] = prog_data;
        build();
        run(2, 0, 0);

        // abort on 5th RUN cycle of step 1, write dropped mid-run
        prog_t1();
        build();
        while (q.size() > 13) void'(q.pop_back());
        ai = q[12][2:0];
        q.push_back(ev(0, 0, 1, 0, '0, 0, 0, ai));
        q.push_back(ev(0, 0, 0, 0, '0, 0, 0, ai));
        run(4, 13, 3);
        build();
        run(41, 0, 0);

        // no last flag anywhere
        for (int k = 0; k < 8; k++) begin
            prog(k, 0, k[0], k[1], k % 5, k + 1);
        end
        build();
        run(5, 0, 0);

        // reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", obs(), ev(0, 0, 0, 0, '0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid2", obs(), ev(0, 0, 0, 0, '0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
